// File: rtl/board_csr_pkg.sv
// Shared constants for the board CSR responder: register map, STICKY bit
// positions and reset values.
package board_csr_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [3:0]  LED_RST = 4'hF;

    // Word addresses
    localparam int unsigned CSR_ID        = 32'd0;
    localparam int unsigned CSR_SCRATCH   = 32'd1;
    localparam int unsigned CSR_LED       = 32'd2;
    localparam int unsigned CSR_STATUS    = 32'd3;
    localparam int unsigned CSR_STICKY    = 32'd4;
    localparam int unsigned CSR_PERST_CNT = 32'd5;
    localparam int unsigned CSR_UPTIME    = 32'd6;
    localparam int unsigned CSR_IRQ_MASK  = 32'd7;

    // STICKY bit indices
    localparam int unsigned STICKY_A_FAIL = 0;
    localparam int unsigned STICKY_B_FAIL = 1;
    localparam int unsigned STICKY_PERST  = 2;
    localparam int unsigned STICKY_W      = 3;

endpackage

// File: rtl/csr_sync2.sv
// Two-flop synchronizer with a configurable reset value per bit.
module csr_sync2 #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_u59,
    input  logic             any_rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state: shift the asynchronous input through two stages
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer flops
    always_ff @(posedge clk_u59 or negedge any_rstn) begin
        if (!any_rstn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/avmm_board_csr_responder.sv
// Avalon-MM CSR responder for the board: ID, scratch, LED control, DDR4
// calibration status, sticky faults, PERST# event counter and uptime.
// Optional build macro CSR_IRQ_EN adds the irq output and the IRQ_MASK register.
module avmm_board_csr_responder
    import board_csr_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter logic [31:0] ID_VALUE     = 32'hCA7A_0003,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk_u59,
    input  logic              any_rstn,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    input  logic              ddr4_a_cal_success,
    input  logic              ddr4_a_cal_fail,
    input  logic              ddr4_b_cal_success,
    input  logic              ddr4_b_cal_fail,
    input  logic              pcie_perstn,
    output logic [3:0]        led_o
`ifdef CSR_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [3:0]  cal_sync;   // {b_fail, b_succ, a_fail, a_succ}
    logic        perstn_sync;
    logic        perst_fall;
    logic [31:0] addr_idx;
    logic        init_q, init_d;
    logic        wr_acc, rd_acc;
    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic [3:0]          led_q, led_d;
    logic [STICKY_W-1:0] sticky_q, sticky_d, sticky_set, sticky_clr;
    logic [31:0]         perst_cnt_q, perst_cnt_d;
    logic [31:0]         uptime_q, uptime_d;
    logic                perstn_prev_q, perstn_prev_d;

    logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]       rd_dat_q [READ_LATENCY];
    logic [DATA_W-1:0]       rd_dat_d [READ_LATENCY];

`ifdef CSR_IRQ_EN
    logic [STICKY_W-1:0] irq_mask_q, irq_mask_d;
    logic                irq_q, irq_d;
`endif

    csr_sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'b0000)
    ) u_sync_cal (
        .clk_u59  (clk_u59),
        .any_rstn (any_rstn),
        .d_i      ({ddr4_b_cal_fail, ddr4_b_cal_success, ddr4_a_cal_fail, ddr4_a_cal_success}),
        .q_o      (cal_sync)
    );

    csr_sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_perstn (
        .clk_u59  (clk_u59),
        .any_rstn (any_rstn),
        .d_i      (pcie_perstn),
        .q_o      (perstn_sync)
    );

    assign addr_idx   = 32'(avs_address);
    assign perst_fall = perstn_prev_q & ~perstn_sync;

    // Handshake: busy for one cycle out of reset; a read colliding with a write is stalled
    always_comb begin
        init_d          = 1'b0;
        avs_waitrequest = init_q | (avs_read & avs_write);
        wr_acc          = avs_write & ~init_q;
        rd_acc          = avs_read & ~avs_write & ~init_q;
    end

    // Read mux, sampled at acceptance
    always_comb begin
        rdata = '0;
        case (addr_idx)
            CSR_ID:        rdata = ID_VALUE;
            CSR_SCRATCH:   rdata = scratch_q;
            CSR_LED:       rdata = {28'b0, led_q};
            CSR_STATUS:    rdata = {28'b0, cal_sync};
            CSR_STICKY:    rdata = {29'b0, sticky_q};
            CSR_PERST_CNT: rdata = perst_cnt_q;
            CSR_UPTIME:    rdata = uptime_q;
`ifdef CSR_IRQ_EN
            CSR_IRQ_MASK:  rdata = {29'b0, irq_mask_q};
`endif
            default:       rdata = '0;
        endcase
    end

    // Register next-state: host writes, hardware status updates and counters
    always_comb begin
        scratch_d     = scratch_q;
        led_d         = led_q;
        perstn_prev_d = perstn_sync;
        uptime_d      = uptime_q + 32'd1;
        perst_cnt_d   = perst_cnt_q;
        sticky_clr    = '0;
`ifdef CSR_IRQ_EN
        irq_mask_d    = irq_mask_q;
        irq_d         = |(sticky_q & irq_mask_q);
`endif
        if (wr_acc) begin
            case (addr_idx)
                CSR_SCRATCH: begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (avs_byteenable[b]) begin
                            scratch_d[8*b +: 8] = avs_writedata[8*b +: 8];
                        end
                    end
                end
                CSR_LED: begin
                    if (avs_byteenable[0]) led_d = avs_writedata[3:0];
                end
                CSR_STICKY: begin
                    if (avs_byteenable[0]) sticky_clr = avs_writedata[STICKY_W-1:0];
                end
`ifdef CSR_IRQ_EN
                CSR_IRQ_MASK: begin
                    if (avs_byteenable[0]) irq_mask_d = avs_writedata[STICKY_W-1:0];
                end
`endif
                default: ;
            endcase
        end
        sticky_set                = '0;
        sticky_set[STICKY_A_FAIL] = cal_sync[1];
        sticky_set[STICKY_B_FAIL] = cal_sync[3];
        sticky_set[STICKY_PERST]  = perst_fall;
        // Hardware set takes priority over a simultaneous W1C
        sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
        if (perst_fall && (perst_cnt_q != 32'hFFFF_FFFF)) begin
            perst_cnt_d = perst_cnt_q + 32'd1;
        end
    end

    // Read pipeline: data stages only load on valid so the output holds its last value
    always_comb begin
        rd_vld_d[0] = rd_acc;
        rd_dat_d[0] = rd_acc ? rdata : rd_dat_q[0];
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_dat_d[i] = rd_vld_q[i-1] ? rd_dat_q[i-1] : rd_dat_q[i];
        end
    end

    // State registers
    always_ff @(posedge clk_u59 or negedge any_rstn) begin
        if (!any_rstn) begin
            init_q        <= 1'b1;
            scratch_q     <= '0;
            led_q         <= LED_RST;
            sticky_q      <= '0;
            perst_cnt_q   <= '0;
            uptime_q      <= '0;
            perstn_prev_q <= 1'b1;
            rd_vld_q      <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) rd_dat_q[i] <= '0;
`ifdef CSR_IRQ_EN
            irq_mask_q    <= '0;
            irq_q         <= 1'b0;
`endif
        end else begin
            init_q        <= init_d;
            scratch_q     <= scratch_d;
            led_q         <= led_d;
            sticky_q      <= sticky_d;
            perst_cnt_q   <= perst_cnt_d;
            uptime_q      <= uptime_d;
            perstn_prev_q <= perstn_prev_d;
            rd_vld_q      <= rd_vld_d;
            rd_dat_q      <= rd_dat_d;
`ifdef CSR_IRQ_EN
            irq_mask_q    <= irq_mask_d;
            irq_q         <= irq_d;
`endif
        end
    end

    assign avs_readdatavalid = rd_vld_q[READ_LATENCY-1];
    assign avs_readdata      = rd_dat_q[READ_LATENCY-1];
    assign led_o             = led_q;
`ifdef CSR_IRQ_EN
    assign irq               = irq_q;
`endif

endmodule

// File: tb/tb_avmm_board_csr_responder.sv
// Directed self-checking bench for avmm_board_csr_responder.
// Build with CSR_IRQ_EN defined to also exercise the irq path.
module tb_avmm_board_csr_responder;

    localparam logic [31:0] ID = 32'hCA7A_0003;

    logic        clk_u59 = 1'b0;
    logic        any_rstn;
    logic [3:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        a_succ, a_fail, b_succ, b_fail, perstn;
    logic [3:0]  led_o;
`ifdef CSR_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  baddr [4] = '{4'h1, 4'h0, 4'h6, 4'h6};
    logic [31:0] bdat  [8];
    logic        bvld  [8];
    logic [31:0] rd;
    int          rdv_seen;

    always #5 clk_u59 = ~clk_u59;

    avmm_board_csr_responder dut (
        .clk_u59            (clk_u59),
        .any_rstn           (any_rstn),
        .avs_address        (avs_address),
        .avs_read           (avs_read),
        .avs_write          (avs_write),
        .avs_writedata      (avs_writedata),
        .avs_byteenable     (avs_byteenable),
        .avs_waitrequest    (avs_waitrequest),
        .avs_readdata       (avs_readdata),
        .avs_readdatavalid  (avs_readdatavalid),
        .ddr4_a_cal_success (a_succ),
        .ddr4_a_cal_fail    (a_fail),
        .ddr4_b_cal_success (b_succ),
        .ddr4_b_cal_fail    (b_fail),
        .pcie_perstn        (perstn),
        .led_o              (led_o)
`ifdef CSR_IRQ_EN
        ,
        .irq                (irq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_accept(input string tag);
        int tries = 0;
        #1;
        while (avs_waitrequest && tries < 8) begin
            @(negedge clk_u59);
            #1;
            tries++;
        end
        check_eq(tag, 32'(avs_waitrequest), 32'h0);
    endtask

    task automatic csr_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        @(negedge clk_u59);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        wait_accept("wr_accept");
        @(posedge clk_u59);
        @(negedge clk_u59);
        avs_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] addr, output logic [31:0] data);
        int lat;
        @(negedge clk_u59);
        avs_address = addr;
        avs_read    = 1'b1;
        wait_accept("rd_accept");
        @(posedge clk_u59);
        @(negedge clk_u59);
        avs_read = 1'b0;
        lat = 1;
        while (!avs_readdatavalid && lat < 8) begin
            @(negedge clk_u59);
            lat++;
        end
        check_eq("rd_latency", 32'(lat), 32'd2);
        data = avs_readdata;
    endtask

    task automatic perst_pulse();
        @(negedge clk_u59);
        perstn = 1'b0;
        repeat (3) @(negedge clk_u59);
        perstn = 1'b1;
        repeat (3) @(negedge clk_u59);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        any_rstn = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        a_succ = 1'b0; a_fail = 1'b0; b_succ = 1'b0; b_fail = 1'b0; perstn = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_u59);
        check_eq("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
        check_eq("rst_rdvalid", 32'(avs_readdatavalid), 32'h0);
        check_eq("rst_readdata", avs_readdata, 32'h0);
        check_eq("rst_led", 32'(led_o), 32'hF);
        any_rstn = 1'b1;
        #1;
        check_eq("wr_hold_after_rst", 32'(avs_waitrequest), 32'h1);
        @(negedge clk_u59);
        check_eq("wr_idle", 32'(avs_waitrequest), 32'h0);

        // ID and LED default
        csr_read(4'h0, rd);
        check_eq("id", rd, ID);
        check_eq("led_default", 32'(led_o), 32'hF);

        // Scratch byte enables, LED control
        csr_write(4'h1, 32'hDEAD_BEEF, 4'b0101);
        csr_read(4'h1, rd);
        check_eq("scratch_be", rd, 32'h00AD_00EF);
        csr_write(4'h2, 32'h0000_0005, 4'b0001);
        check_eq("led_write", 32'(led_o), 32'h5);
        csr_write(4'h2, 32'h0000_000A, 4'b1110);
        check_eq("led_lane0_only", 32'(led_o), 32'h5);
        csr_read(4'h2, rd);
        check_eq("led_readback", rd, 32'h5);

        // Reserved space
        csr_write(4'h9, 32'hFFFF_FFFF, 4'hF);
        csr_read(4'h9, rd);
        check_eq("reserved_9", rd, 32'h0);
        csr_read(4'h7, rd);
        check_eq("reserved_or_mask_7", rd, 32'h0);

        // Status and sticky
        b_succ = 1'b1;
        a_fail = 1'b1;
        repeat (4) @(negedge clk_u59);
        csr_read(4'h3, rd);
        check_eq("status_afail", rd, 32'h6);
        csr_read(4'h4, rd);
        check_eq("sticky_afail", rd, 32'h1);
        a_fail = 1'b0;
        repeat (4) @(negedge clk_u59);
        csr_read(4'h3, rd);
        check_eq("status_clear", rd, 32'h4);
        csr_read(4'h4, rd);
        check_eq("sticky_holds", rd, 32'h1);
        a_fail = 1'b1;
        repeat (4) @(negedge clk_u59);
        csr_write(4'h4, 32'h1, 4'b0001);
        csr_read(4'h4, rd);
        check_eq("sticky_set_wins", rd, 32'h1);
        a_fail = 1'b0;
        repeat (4) @(negedge clk_u59);
        csr_write(4'h4, 32'h1, 4'b0000);
        csr_read(4'h4, rd);
        check_eq("sticky_be_gated", rd, 32'h1);
        csr_write(4'h4, 32'h1, 4'b0001);
        csr_read(4'h4, rd);
        check_eq("sticky_w1c", rd, 32'h0);

        // PERST# edges and saturation
        repeat (3) perst_pulse();
        csr_read(4'h5, rd);
        check_eq("perst_cnt", rd, 32'd3);
        csr_read(4'h4, rd);
        check_eq("sticky_perst", rd, 32'h4);
        @(negedge clk_u59);
        force dut.perst_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk_u59);
        release dut.perst_cnt_q;
        perst_pulse();
        csr_read(4'h5, rd);
        check_eq("perst_cnt_sat", rd, 32'hFFFF_FFFF);

        // Simultaneous read and write: write wins, read follows
        @(negedge clk_u59);
        avs_address = 4'h1; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
        avs_read = 1'b1; avs_write = 1'b1;
        #1;
        check_eq("rw_collision_wait", 32'(avs_waitrequest), 32'h1);
        @(negedge clk_u59);
        avs_write = 1'b0;
        #1;
        check_eq("rw_read_ready", 32'(avs_waitrequest), 32'h0);
        check_eq("rw_no_early_valid", 32'(avs_readdatavalid), 32'h0);
        @(negedge clk_u59);
        avs_read = 1'b0;
        check_eq("rw_valid_pending", 32'(avs_readdatavalid), 32'h0);
        @(negedge clk_u59);
        check_eq("rw_valid", 32'(avs_readdatavalid), 32'h1);
        check_eq("rw_data", avs_readdata, 32'h1234_5678);

        // Four back-to-back reads
        @(negedge clk_u59);
        avs_address = baddr[0];
        avs_read    = 1'b1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk_u59);
            bvld[k] = avs_readdatavalid;
            bdat[k] = avs_readdata;
            if (k < 4) avs_address = baddr[k];
            else       avs_read = 1'b0;
        end
        check_eq("burst_vld1", 32'(bvld[1]), 32'h0);
        check_eq("burst_vld2", 32'(bvld[2]), 32'h1);
        check_eq("burst_vld3", 32'(bvld[3]), 32'h1);
        check_eq("burst_vld4", 32'(bvld[4]), 32'h1);
        check_eq("burst_vld5", 32'(bvld[5]), 32'h1);
        check_eq("burst_vld6", 32'(bvld[6]), 32'h0);
        check_eq("burst_dat0", bdat[2], 32'h1234_5678);
        check_eq("burst_dat1", bdat[3], ID);
        check_eq("uptime_step", bdat[5], bdat[4] + 32'd1);
        check_eq("rdata_hold", avs_readdata, bdat[5]);

`ifdef CSR_IRQ_EN
        // Interrupt on masked sticky bit
        csr_write(4'h7, 32'h1, 4'b0001);
        csr_read(4'h7, rd);
        check_eq("irq_mask", rd, 32'h1);
        check_eq("irq_idle", 32'(irq), 32'h0);
        a_fail = 1'b1;
        repeat (5) @(negedge clk_u59);
        check_eq("irq_set", 32'(irq), 32'h1);
        a_fail = 1'b0;
        repeat (4) @(negedge clk_u59);
        csr_write(4'h4, 32'h1, 4'b0001);
        check_eq("irq_lag", 32'(irq), 32'h1);
        @(negedge clk_u59);
        check_eq("irq_clear", 32'(irq), 32'h0);
`endif

        // Reset with reads in flight
        @(negedge clk_u59);
        avs_address = 4'h0;
        avs_read    = 1'b1;
        @(negedge clk_u59);
        avs_address = 4'h1;
        @(negedge clk_u59);
        avs_read = 1'b0;
        any_rstn = 1'b0;
        #1;
        check_eq("rst_kill_valid", 32'(avs_readdatavalid), 32'h0);
        repeat (2) @(negedge clk_u59);
        any_rstn = 1'b1;
        rdv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_u59);
            if (avs_readdatavalid) rdv_seen++;
        end
        check_eq("no_valid_after_rst", 32'(rdv_seen), 32'h0);
        check_eq("led_after_rst", 32'(led_o), 32'hF);
        csr_read(4'h1, rd);
        check_eq("scratch_after_rst", rd, 32'h0);
        csr_read(4'h5, rd);
        check_eq("perst_cnt_after_rst", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
